// File: rtl/fir_mc_fixed.sv
// Multi-channel fixed-point FIR: NCH interleaved delay lines sharing one coefficient set and one MAC.
// Define FIR_SAT_EN to saturate on output narrowing; otherwise the result wraps (truncates).
module fir_mc_fixed #(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int COEF_FRAC = 15,
   parameter int TAPS      = 8,
   parameter int NCH       = 2
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic                                      stop,
   input  logic [DATA_W-1:0]                         in,
   output logic                                      next,
   output logic [DATA_W-1:0]                         out,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  out_ch,
   output logic                                      ready,
   output logic                                      busy,
   output logic                                      done,
   input  logic                                      coef_we,
   input  logic [$clog2(TAPS)-1:0]                   coef_addr,
   input  logic [COEF_W-1:0]                         coef_data
);

   localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int AW     = $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + $clog2(TAPS);
   localparam int RND_SH = (COEF_FRAC > 0) ? COEF_FRAC - 1 : 0;
   localparam logic [ACC_W:0] RND_C = (COEF_FRAC > 0) ?
                                      ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : {(ACC_W+1){1'b0}};
`ifdef FIR_SAT_EN
   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAP, S_MAC, S_OUT} state_t;

   state_t                    state_r;
   logic signed [DATA_W-1:0]  x_r [NCH][TAPS];
   logic signed [COEF_W-1:0]  c_r [TAPS];
   logic [AW-1:0]             idx_r;
   logic [CH_W-1:0]           ch_r;
   logic signed [ACC_W-1:0]   acc_r;

   logic signed [DATA_W-1:0]  x_sel_s;
   logic signed [COEF_W-1:0]  c_sel_s;
   logic signed [PROD_W-1:0]  prod_s;
   logic signed [ACC_W-1:0]   acc_sum_s;

   // Round half up by the coefficient fraction, then narrow to the sample width.
   function automatic logic [DATA_W-1:0] fmt(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W:0] r;
      r = ($signed({a[ACC_W-1], a}) + $signed(RND_C)) >>> COEF_FRAC;
`ifdef FIR_SAT_EN
      if (r > SAT_MAX) begin
         fmt = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (r < SAT_MIN) begin
         fmt = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         fmt = r[DATA_W-1:0];
      end
`else
      fmt = r[DATA_W-1:0];
`endif
   endfunction

   // Shared MAC datapath: one tap of the active channel per cycle.
   always_comb begin
      x_sel_s   = x_r[ch_r][idx_r];
      c_sel_s   = c_r[idx_r];
      prod_s    = PROD_W'(x_sel_s) * PROD_W'(c_sel_s);
      acc_sum_s = acc_r + ACC_W'(prod_s);
   end

   // Control FSM with registered handshake outputs, delay lines and coefficient store.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         next    <= 1'b0;
         ready   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         out     <= {DATA_W{1'b0}};
         out_ch  <= {CH_W{1'b0}};
         ch_r    <= {CH_W{1'b0}};
         idx_r   <= {AW{1'b0}};
         acc_r   <= {ACC_W{1'b0}};
         for (int n = 0; n < NCH; n++) begin
            for (int k = 0; k < TAPS; k++) begin
               x_r[n][k] <= {DATA_W{1'b0}};
            end
         end
         for (int k = 0; k < TAPS; k++) begin
            c_r[k] <= {COEF_W{1'b0}};
         end
      end else begin
         next  <= 1'b0;
         ready <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (coef_we) begin
                  c_r[coef_addr] <= coef_data;
               end
               if (start) begin
                  done    <= 1'b0;
                  busy    <= 1'b1;
                  next    <= 1'b1;
                  state_r <= S_REQ;
               end
            end
            S_REQ: begin
               state_r <= S_CAP;
            end
            S_CAP: begin
               // On stop the sample is dropped unseen, so an undriven bus is harmless.
               if (stop) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  x_r[ch_r][0] <= in;
                  for (int k = 1; k < TAPS; k++) begin
                     x_r[ch_r][k] <= x_r[ch_r][k-1];
                  end
                  idx_r   <= {AW{1'b0}};
                  acc_r   <= {ACC_W{1'b0}};
                  state_r <= S_MAC;
               end
            end
            S_MAC: begin
               acc_r <= acc_sum_s;
               if (idx_r == AW'(TAPS-1)) begin
                  out     <= fmt(acc_sum_s);
                  out_ch  <= ch_r;
                  ready   <= 1'b1;
                  state_r <= S_OUT;
               end else begin
                  idx_r <= idx_r + AW'(1);
               end
            end
            S_OUT: begin
               ch_r <= (ch_r == CH_W'(NCH-1)) ? {CH_W{1'b0}} : ch_r + CH_W'(1);
               if (stop) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  next    <= 1'b1;
                  state_r <= S_REQ;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule
